// File: rtl/neuron_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment: the neuron SRAM port,
// the IF neuron control and result lines, and the AER spike output handshake.
interface neuron_sweep_ctrl_if #(
    parameter int AER_WIDTH                 = 8,
    parameter int POST_NEUR_MEM_WIDTH       = 12,
    parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7
);
    logic                                                     sram_cs;
    logic                                                     sram_we;
    logic [AER_WIDTH-1:0]                                     sram_addr;
    logic [POST_NEUR_SPIKE_CNT_WIDTH+POST_NEUR_MEM_WIDTH-1:0] sram_wdata;
    logic [POST_NEUR_MEM_WIDTH-1:0]                           nrn_state_next;
    logic [POST_NEUR_SPIKE_CNT_WIDTH-1:0]                     nrn_cnt_next;
    logic                                                     nrn_spike;
    logic                                                     time_step_event;
    logic                                                     time_ref_event;
    logic                                                     aer_valid;
    logic [AER_WIDTH-1:0]                                     aer_addr;
    logic                                                     aer_ready;

    modport master (
        output sram_cs, sram_we, sram_addr, sram_wdata,
        output time_step_event, time_ref_event,
        output aer_valid, aer_addr,
        input  nrn_state_next, nrn_cnt_next, nrn_spike,
        input  aer_ready
    );

    modport slave (
        input  sram_cs, sram_we, sram_addr, sram_wdata,
        input  time_step_event, time_ref_event,
        input  aer_valid, aer_addr,
        output nrn_state_next, nrn_cnt_next, nrn_spike,
        output aer_ready
    );
endinterface

// File: rtl/neuron_sweep_ctrl.sv
// Time-step sequencer for the post-synaptic layer: read/evaluate/write-back every neuron,
// emit AER events for spikes, and clear all neurons after the last step of a sample.
module neuron_sweep_ctrl #(
    parameter int  N_NEUR                    = 256,
    parameter int  AER_WIDTH                 = 8,
    parameter int  TIME_STEP                 = 8,
    parameter int  POST_NEUR_MEM_WIDTH       = 12,
    parameter int  POST_NEUR_SPIKE_CNT_WIDTH = 7,
    localparam int TS_WIDTH                  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ts_start,
    output logic                    busy,
    output logic                    done,
    output logic [TS_WIDTH-1:0]     current_time_step,
    neuron_sweep_ctrl_if.master     bus
);

    localparam logic [AER_WIDTH-1:0] LAST_ADDR = AER_WIDTH'(N_NEUR - 1);
    localparam logic [TS_WIDTH-1:0]  LAST_TS   = TS_WIDTH'(TIME_STEP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StEval,
        StAer,
        StEnd,
        StRef,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [AER_WIDTH-1:0]   addr_q, addr_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [AER_WIDTH-1:0]   aer_addr_q, aer_addr_d;
    logic                   last_addr;

    assign last_addr         = (addr_q == LAST_ADDR);
    assign current_time_step = ts_q;
    assign bus.aer_addr      = aer_addr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            ts_q       <= '0;
            aer_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ts_q       <= ts_d;
            aer_addr_q <= aer_addr_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        ts_d                = ts_q;
        aer_addr_d          = aer_addr_q;
        busy                = 1'b0;
        done                = 1'b0;
        bus.sram_cs         = 1'b0;
        bus.sram_we         = 1'b0;
        bus.sram_addr       = '0;
        bus.sram_wdata      = '0;
        bus.time_step_event = 1'b0;
        bus.time_ref_event  = 1'b0;
        bus.aer_valid       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ts_start) begin
                    addr_d  = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                busy          = 1'b1;
                bus.sram_cs   = 1'b1;
                bus.sram_addr = addr_q;
                state_d       = StEval;
            end
            StEval: begin
                // Read data reached the neuron last cycle; write its result back now.
                busy                = 1'b1;
                bus.time_step_event = 1'b1;
                bus.sram_cs         = 1'b1;
                bus.sram_we         = 1'b1;
                bus.sram_addr       = addr_q;
                bus.sram_wdata      = {bus.nrn_cnt_next, bus.nrn_state_next};
                if (bus.nrn_spike) begin
                    aer_addr_d = addr_q;
                    state_d    = StAer;
                end else if (!last_addr) begin
                    addr_d  = addr_q + AER_WIDTH'(1);
                    state_d = StRd;
                end else begin
                    state_d = StEnd;
                end
            end
            StAer: begin
                busy          = 1'b1;
                bus.aer_valid = 1'b1;
                if (bus.aer_ready) begin
                    if (last_addr) begin
                        state_d = StEnd;
                    end else begin
                        addr_d  = addr_q + AER_WIDTH'(1);
                        state_d = StRd;
                    end
                end
            end
            StEnd: begin
                busy = 1'b1;
                if (ts_q == LAST_TS) begin
                    ts_d    = '0;
                    addr_d  = '0;
                    state_d = StRef;
                end else begin
                    ts_d    = ts_q + TS_WIDTH'(1);
                    state_d = StDone;
                end
            end
            StRef: begin
                // Neuron drives zeros while time_ref_event is high.
                busy               = 1'b1;
                bus.time_ref_event = 1'b1;
                bus.sram_cs        = 1'b1;
                bus.sram_we        = 1'b1;
                bus.sram_addr      = addr_q;
                bus.sram_wdata     = {bus.nrn_cnt_next, bus.nrn_state_next};
                if (last_addr) begin
                    state_d = StDone;
                end else begin
                    addr_d = addr_q + AER_WIDTH'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Scoreboard bench for neuron_sweep_ctrl with a 4-neuron layer: stimulus queues the expected
// SRAM/AER/done events with their cycle numbers, a negedge monitor pops and compares them.
module tb_neuron_sweep_ctrl;

    localparam int N_NEUR    = 4;
    localparam int AER_W     = 8;
    localparam int TIME_STEP = 8;
    localparam int MEM_W     = 12;
    localparam int CNT_W     = 7;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_AER   = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        int          addr;
        logic [18:0] data;
        logic [1:0]  ev;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ts_start;
    logic       busy;
    logic       done;
    logic [2:0] current_time_step;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         sweep_id = 0;
    int         ready_stall = 0;
    int         stall_cnt = 0;
    logic [3:0] spike_mask = '0;
    int         probe_kind = 0;
    int         probe_seq = 0;
    int         probe_seen = 0;
    ev_t        exp_q[$];

    neuron_sweep_ctrl_if #(
        .AER_WIDTH(AER_W),
        .POST_NEUR_MEM_WIDTH(MEM_W),
        .POST_NEUR_SPIKE_CNT_WIDTH(CNT_W)
    ) bus ();

    neuron_sweep_ctrl #(
        .N_NEUR(N_NEUR),
        .AER_WIDTH(AER_W),
        .TIME_STEP(TIME_STEP),
        .POST_NEUR_MEM_WIDTH(MEM_W),
        .POST_NEUR_SPIKE_CNT_WIDTH(CNT_W)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .ts_start(ts_start),
        .busy(busy),
        .done(done),
        .current_time_step(current_time_step),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        stall_cnt <= bus.aer_valid ? stall_cnt + 1 : 0;
    end

    assign bus.aer_ready = (stall_cnt >= ready_stall);

    // Stand-in neuron: result depends on address and sweep so each write is distinguishable.
    always_comb begin
        bus.nrn_state_next = '0;
        bus.nrn_cnt_next   = '0;
        bus.nrn_spike      = 1'b0;
        if (bus.time_step_event) begin
            bus.nrn_state_next = 12'(256 + 16 * int'(bus.sram_addr) + sweep_id);
            bus.nrn_cnt_next   = 7'(int'(bus.sram_addr) + 4 * sweep_id);
            bus.nrn_spike      = spike_mask[bus.sram_addr[1:0]];
        end
    end

    function automatic logic [18:0] exp_data(input int a, input int sid);
        return {7'(a + 4 * sid), 12'(256 + 16 * a + sid)};
    endfunction

    task automatic observe(input int kind, input int addr, input logic [18:0] data,
                           input logic [1:0] ev);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%0d required=none",
                     kind, cyc, addr);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_timing got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                         kind, cyc, e.kind, e.cyc);
            end
            checks++;
            if (e.addr != addr || e.data != data || e.ev != ev) begin
                failures++;
                $display("FAIL event_payload kind=%0d cyc=%0d got addr=%0d data=%h ev=%b required addr=%0d data=%h ev=%b",
                         kind, cyc, addr, data, ev, e.addr, e.data, e.ev);
            end
        end
    endtask

    always @(negedge clk) begin
        if (probe_seq != probe_seen) begin
            probe_seen = probe_seq;
            checks++;
            if (probe_kind == 1) begin
                if (busy || done || bus.sram_cs || bus.sram_we || bus.sram_addr != 0 ||
                    bus.sram_wdata != 0 || bus.time_step_event || bus.time_ref_event ||
                    bus.aer_valid || bus.aer_addr != 0 || current_time_step != 0) begin
                    failures++;
                    $display("FAIL reset_outputs got busy=%b done=%b cs=%b we=%b addr=%0d wd=%h tse=%b tre=%b av=%b aa=%0d ts=%0d required all zero",
                             busy, done, bus.sram_cs, bus.sram_we, bus.sram_addr,
                             bus.sram_wdata, bus.time_step_event, bus.time_ref_event,
                             bus.aer_valid, bus.aer_addr, current_time_step);
                end
            end else if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL missing_events got pending=%0d required=0 next kind=%0d cyc=%0d",
                         exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
                exp_q.delete();
            end
        end
        if (!rst) begin
            if (bus.sram_cs && bus.sram_we)
                observe(K_WRITE, int'(bus.sram_addr), bus.sram_wdata,
                        {bus.time_step_event, bus.time_ref_event});
            else if (bus.sram_cs)
                observe(K_READ, int'(bus.sram_addr), 19'(busy), 2'b00);
            if (bus.aer_valid && bus.aer_ready)
                observe(K_AER, int'(bus.aer_addr), '0, 2'b00);
            if (done)
                observe(K_DONE, int'(current_time_step), 19'(busy), 2'b00);
        end
    end

    task automatic push(input int kind, input int c, input int addr, input logic [18:0] data,
                        input logic [1:0] ev);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = addr;
        e.data = data;
        e.ev   = ev;
        exp_q.push_back(e);
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input int k);
        probe_kind = k;
        probe_seq++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ts_start = 1'b1;
        @(posedge clk);
        #1;
        ts_start = 1'b0;
    endtask

    // Cycle 0 is the cycle in which ts_start is high.
    task automatic run_sweep(input logic [3:0] mask, input int stall, input bit wrap,
                             input int ts_after, input bit extra_pulses);
        int base;
        int c;
        spike_mask  = mask;
        ready_stall = stall;
        sweep_id++;
        base = cyc;
        c    = base + 1;
        for (int i = 0; i < N_NEUR; i++) begin
            push(K_READ, c, i, 19'd1, 2'b00);
            push(K_WRITE, c + 1, i, exp_data(i, sweep_id), 2'b10);
            c += 2;
            if (mask[i]) begin
                push(K_AER, c + stall, i, '0, 2'b00);
                c += stall + 1;
            end
        end
        c++;
        if (wrap) begin
            for (int i = 0; i < N_NEUR; i++) begin
                push(K_WRITE, c, i, '0, 2'b01);
                c++;
            end
        end
        push(K_DONE, c, ts_after, '0, 2'b00);
        pulse_start();
        if (extra_pulses) begin
            goto_cycle(base + 3);
            pulse_start();
            goto_cycle(c);
            pulse_start();
        end
        goto_cycle(c + 4);
        probe(2);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        ts_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        probe(1);

        // No spikes: done at cycle 10, step 0 -> 1.
        run_sweep(4'b0000, 0, 1'b0, 1, 1'b0);
        // Neuron 2 fires, downstream stalls 3 cycles.
        run_sweep(4'b0100, 3, 1'b0, 2, 1'b0);
        // ts_start while busy and in the done cycle must not restart.
        run_sweep(4'b0000, 0, 1'b0, 3, 1'b1);
        // All neurons fire: done at cycle 14.
        run_sweep(4'b1111, 0, 1'b0, 4, 1'b0);
        run_sweep(4'b0000, 0, 1'b0, 5, 1'b0);
        run_sweep(4'b0010, 0, 1'b0, 6, 1'b0);
        run_sweep(4'b0000, 0, 1'b0, 7, 1'b0);
        // Last time step: reference sweep clears all neurons and step wraps to 0.
        run_sweep(4'b0000, 0, 1'b1, 0, 1'b0);

        // Reset right after EVAL of address 1 aborts the sweep.
        run_sweep(4'b0000, 0, 1'b0, 1, 1'b0);
        spike_mask = 4'b0000;
        sweep_id++;
        base = cyc;
        push(K_READ, base + 1, 0, 19'd1, 2'b00);
        push(K_WRITE, base + 2, 0, exp_data(0, sweep_id), 2'b10);
        push(K_READ, base + 3, 1, 19'd1, 2'b00);
        push(K_WRITE, base + 4, 1, exp_data(1, sweep_id), 2'b10);
        pulse_start();
        goto_cycle(base + 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe(1);
        goto_cycle(base + 20);
        probe(2);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_sweep_ctrl.md
Name: neuron_sweep_ctrl

Overview:
- Sequencer that closes each time step of the post-synaptic layer.
- On a start pulse it walks every post-neuron address and reads that neuron's membrane state and spike count from SRAM.
- It drives the IF neuron with the time-step event, writes the neuron's next state and count back, and emits an AER output event for every neuron that fires.
- After the last time step of a sample it runs a reference sweep that clears every neuron. It sits directly upstream of the IF neuron (control and timing) and downstream of it (write-back and spike capture).

Parameters:
- N_NEUR, 256: number of post-neurons swept.
- AER_WIDTH, 8: neuron address width; must satisfy 2^AER_WIDTH >= N_NEUR.
- TIME_STEP, 8: time steps per sample.
- POST_NEUR_MEM_WIDTH, 12: membrane state width.
- POST_NEUR_SPIKE_CNT_WIDTH, 7: spike-count width.

Ports:
- CLK  in  1  clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- ts_start  in  1  one-cycle pulse that starts a time-step sweep.
- busy  out  1  high from the cycle after an accepted ts_start until done.
- done  out  1  one-cycle pulse when the sweep (including any reference sweep) is complete.
- sram_cs  out  1  neuron SRAM chip select.
- sram_we  out  1  neuron SRAM write enable.
- sram_addr  out  AER_WIDTH  neuron SRAM address.
- sram_wdata  out  POST_NEUR_SPIKE_CNT_WIDTH+POST_NEUR_MEM_WIDTH  write data, {cnt_next, state_next}.
- nrn_state_next  in  POST_NEUR_MEM_WIDTH  neuron next membrane state.
- nrn_cnt_next  in  POST_NEUR_SPIKE_CNT_WIDTH  neuron next spike count.
- nrn_spike  in  1  neuron spike output.
- time_step_event  out  1  to neuron; evaluate fire, reset and count.
- time_ref_event  out  1  to neuron; clear state and count.
- current_time_step  out  clog2(TIME_STEP)  time-step index, stable for the whole sweep.
- aer_valid  out  1  output spike event valid.
- aer_addr  out  AER_WIDTH  address of the firing neuron.
- aer_ready  in  1  downstream accepts the event.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; current_time_step 0. Reset mid-sweep aborts the sweep immediately: no further write and no done.
- SRAM read latency is 1 cycle. Read data goes straight to the neuron and does not pass through this block.
- IDLE:
  - ts_start=1 -> RD, address a=0, busy=1.
  - ts_start while busy is ignored.
- RD: sram_cs=1, sram_we=0, sram_addr=a -> EVAL.
- EVAL:
  - Outputs: time_step_event=1, sram_cs=1, sram_we=1, sram_addr=a, sram_wdata={nrn_cnt_next, nrn_state_next}. The write-back is combinational from the neuron outputs in the same cycle.
  - If nrn_spike=1: register aer_addr=a, then go to AER.
  - Else, if a<N_NEUR-1: a+1, then go to RD.
  - Else go to END.
- AER:
  - aer_valid=1 with aer_addr held until aer_ready=1.
  - The transfer happens in the cycle with aer_valid and aer_ready both high. aer_valid drops the following cycle.
  - Then go to RD with a+1, or to END if a=N_NEUR-1.
  - No SRAM access in this state. aer_valid must not depend combinationally on aer_ready.
- END: one cycle, no SRAM access.
  - If current_time_step=TIME_STEP-1: current_time_step wraps to 0, a=0, go to REF.
  - Else: current_time_step+1, go to DONE.
- REF: one neuron per cycle.
  - Outputs: time_ref_event=1, sram_cs=1, sram_we=1, sram_addr=a, sram_wdata from the neuron (zeros).
  - a=N_NEUR-1 -> DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- time_step_event and time_ref_event are never high together, and are never high outside EVAL and REF respectively.
- Cycle counts, with S = number of firing neurons:
  - Time-step sweep: 2*N_NEUR + S + 2 cycles from ts_start to done when aer_ready is always high.
  - A reference sweep adds N_NEUR cycles.
- A ts_start arriving in the same cycle as done is ignored; it is accepted only in IDLE.

Test Plan:
- N_NEUR=4, TIME_STEP=8, no spikes, aer_ready=1; pulse ts_start -> writes to addresses 0,1,2,3 in cycles 2,4,6,8 after ts_start; done at cycle 10; current_time_step becomes 1; aer_valid never high.
- Neuron 2 spikes, aer_ready held low 3 cycles -> aer_valid=1 with aer_addr=2 for 4 cycles; the RD of address 3 waits; total latency grows by 4 cycles; exactly one event is transferred.
- Eight consecutive sweeps -> on the 8th, current_time_step wraps 7->0; REF writes zeros to addresses 0..3 with time_ref_event=1 for 4 cycles; done follows.
- ts_start pulsed while busy, and in the done cycle -> no restart; exactly one done per accepted start.
- RST asserted in the cycle after EVAL of address 1 -> all outputs 0 in the next cycle; no further writes; no done; current_time_step=0.
- All 4 neurons spike with aer_ready=1 -> AER events carry addresses 0,1,2,3 in order; done at cycle 14.
